// File: rtl/hdmi_timing_gen.sv
// Raster timing generator for the HDMI pixel clock domain: sync/DE, raster position, line/frame strobes.
// Every output is registered from next-state decode, so flags line up with the h_count/v_count shown alongside them.
module hdmi_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic       clk_hdmi,
   input  logic       rst,
   input  logic       en,
   output logic       HDMI_DE,
   output logic       HDMI_HSYNC,
   output logic       HDMI_VSYNC,
   output logic [9:0] h_count,
   output logic [9:0] v_count,
   output logic       line_start,
   output logic       frame_start,
   output logic [7:0] frame_count
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_FP_START   = 10'(H_ACTIVE);
   localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] H_BP_START   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);

   localparam logic [9:0] V_FP_START   = 10'(V_ACTIVE);
   localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] V_BP_START   = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);

   typedef enum logic [1:0] {HS_ACT, HS_FP, HS_SYNC, HS_BP} h_state_t;
   typedef enum logic [1:0] {VS_ACT, VS_FP, VS_SYNC, VS_BP} v_state_t;

   h_state_t   h_state, h_state_nxt;
   v_state_t   v_state, v_state_nxt;
   logic [9:0] h_nxt, v_nxt;
   logic       h_wrap;
   logic       de_nxt, hsync_nxt, vsync_nxt, ls_nxt, fs_nxt;

   always_comb begin
      h_nxt       = h_count;
      v_nxt       = v_count;
      h_wrap      = 1'b0;
      h_state_nxt = h_state;
      v_state_nxt = v_state;

      if (en) begin
         if (h_count == H_LAST) begin
            h_nxt  = '0;
            h_wrap = 1'b1;
         end else begin
            h_nxt = h_count + 10'd1;
         end
         if (h_wrap) begin
            v_nxt = (v_count == V_LAST) ? 10'd0 : v_count + 10'd1;
         end
      end

      // State changes are keyed on the pixel/line that starts each region.
      if (h_nxt == 10'd0)             h_state_nxt = HS_ACT;
      else if (h_nxt == H_FP_START)   h_state_nxt = HS_FP;
      else if (h_nxt == H_SYNC_START) h_state_nxt = HS_SYNC;
      else if (h_nxt == H_BP_START)   h_state_nxt = HS_BP;

      if (v_nxt == 10'd0)             v_state_nxt = VS_ACT;
      else if (v_nxt == V_FP_START)   v_state_nxt = VS_FP;
      else if (v_nxt == V_SYNC_START) v_state_nxt = VS_SYNC;
      else if (v_nxt == V_BP_START)   v_state_nxt = VS_BP;

      de_nxt    = (h_state_nxt == HS_ACT) && (v_state_nxt == VS_ACT);
      hsync_nxt = (h_state_nxt != HS_SYNC);
      vsync_nxt = (v_state_nxt != VS_SYNC);
      // Strobes need en so a held position never re-issues them.
      ls_nxt    = en && (h_nxt == 10'd0);
      fs_nxt    = ls_nxt && (v_nxt == 10'd0);
   end

   always_ff @(posedge clk_hdmi) begin
      if (rst) begin
         h_count     <= H_LAST;
         v_count     <= V_LAST;
         h_state     <= HS_BP;
         v_state     <= VS_BP;
         HDMI_DE     <= 1'b0;
         HDMI_HSYNC  <= 1'b1;
         HDMI_VSYNC  <= 1'b1;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         frame_count <= 8'd0;
      end else begin
         h_count     <= h_nxt;
         v_count     <= v_nxt;
         h_state     <= h_state_nxt;
         v_state     <= v_state_nxt;
         HDMI_DE     <= de_nxt;
         HDMI_HSYNC  <= hsync_nxt;
         HDMI_VSYNC  <= vsync_nxt;
         line_start  <= ls_nxt;
         frame_start <= fs_nxt;
         if (fs_nxt) frame_count <= frame_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Bench for hdmi_timing_gen on a shrunken 15x8 raster; stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_hdmi_timing_gen;

   localparam int HA = 8, HF = 2, HS = 3, HB = 2;
   localparam int VA = 4, VF = 1, VS = 2, VB = 1;
   localparam int HT = HA + HF + HS + HB;   // 15
   localparam int VT = VA + VF + VS + VB;   // 8
   localparam int FRAME = HT * VT;          // 120

   logic       clk_hdmi = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       HDMI_DE, HDMI_HSYNC, HDMI_VSYNC;
   logic [9:0] h_count, v_count;
   logic       line_start, frame_start;
   logic [7:0] frame_count;

   hdmi_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
   ) dut (
      .clk_hdmi(clk_hdmi), .rst(rst), .en(en),
      .HDMI_DE(HDMI_DE), .HDMI_HSYNC(HDMI_HSYNC), .HDMI_VSYNC(HDMI_VSYNC),
      .h_count(h_count), .v_count(v_count),
      .line_start(line_start), .frame_start(frame_start), .frame_count(frame_count)
   );

   always #5 clk_hdmi = ~clk_hdmi;

   typedef struct {
      string name;
      int    h, v, fc;
      bit    de, hs, vs, ls, fs;
      bit    meas;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;
   bit   meas = 1'b0;
   int   ls_expect = 0;

   task automatic chk(input string nm, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         if (failures <= 40) $display("FAIL %s got=%0d want=%0d at %0t", nm, got, want, $time);
      end
   endtask

   // Reference raster: position counters plus region membership tests.
   int mh, mv, mfc;
   bit mls, mfs;

   task automatic model_adv(input bit r, input bit e);
      if (r) begin
         mh = HT - 1; mv = VT - 1; mfc = 0; mls = 0; mfs = 0;
      end else if (e) begin
         if (mh == HT - 1) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
         end else begin
            mh = mh + 1;
         end
         mls = (mh == 0);
         mfs = mls && (mv == 0);
         if (mfs) mfc = (mfc + 1) % 256;
      end else begin
         mls = 0; mfs = 0;
      end
   endtask

   task automatic step(input bit r, input bit e);
      exp_t x;
      rst = r; en = e;
      @(posedge clk_hdmi);
      model_adv(r, e);
      x.name = "model"; x.h = mh; x.v = mv; x.fc = mfc;
      x.de = (mh < HA) && (mv < VA);
      x.hs = !((mh >= HA + HF) && (mh < HA + HF + HS));
      x.vs = !((mv >= VA + VF) && (mv < VA + VF + VS));
      x.ls = mls; x.fs = mfs; x.meas = meas;
      q.push_back(x);
      #1;
   endtask

   task automatic stepd(input bit r, input bit e, input string nm, input int h, input int v,
                        input bit de, input bit hs, input bit vs, input bit ls, input bit fs, input int fc);
      exp_t x;
      rst = r; en = e;
      @(posedge clk_hdmi);
      model_adv(r, e);
      x.name = nm; x.h = h; x.v = v; x.fc = fc;
      x.de = de; x.hs = hs; x.vs = vs; x.ls = ls; x.fs = fs; x.meas = meas;
      q.push_back(x);
      #1;
   endtask

   task automatic run_until(input int th, input int tv);
      int n = 0;
      while (!(mh == th && mv == tv) && n < 2 * FRAME + 5) begin
         step(0, 1);
         n++;
      end
      if (!(mh == th && mv == tv)) begin
         failures++;
         $display("FAIL run_until got=%0d,%0d want=%0d,%0d", mh, mv, th, tv);
      end
   endtask

   // Monitor: one expectation per cycle, plus run-length measurements.
   int fs_gap = 0, de_cnt = 0, hs_run = 0, vs_run = 0, ls_gap = 0;
   bit fs_prev = 0, hs_ok = 0, vs_ok = 0, ls_prev = 0;

   always @(negedge clk_hdmi) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk({e.name, " h_count"},     int'(h_count),     e.h);
         chk({e.name, " v_count"},     int'(v_count),     e.v);
         chk({e.name, " HDMI_DE"},     int'(HDMI_DE),     int'(e.de));
         chk({e.name, " HDMI_HSYNC"},  int'(HDMI_HSYNC),  int'(e.hs));
         chk({e.name, " HDMI_VSYNC"},  int'(HDMI_VSYNC),  int'(e.vs));
         chk({e.name, " line_start"},  int'(line_start),  int'(e.ls));
         chk({e.name, " frame_start"}, int'(frame_start), int'(e.fs));
         chk({e.name, " frame_count"}, int'(frame_count), e.fc);

         if (line_start) begin
            if (ls_prev && ls_expect != 0) begin
               chk("line_gap_after_stall", ls_gap, ls_expect);
               ls_expect = 0;
            end else if (ls_prev && e.meas) begin
               chk("line_gap", ls_gap, HT);
            end
            ls_prev = 1; ls_gap = 1;
         end else begin
            ls_gap++;
         end

         if (!e.meas) begin
            fs_prev = 0; hs_ok = 0; hs_run = 0; vs_ok = 0; vs_run = 0;
         end else begin
            if (frame_start) begin
               if (fs_prev) begin
                  chk("frame_gap", fs_gap, FRAME);
                  chk("de_per_frame", de_cnt, HA * VA);
               end
               fs_prev = 1; fs_gap = 1; de_cnt = int'(HDMI_DE);
            end else begin
               fs_gap++;
               de_cnt += int'(HDMI_DE);
            end
            if (!HDMI_HSYNC) hs_run++;
            else begin
               if (hs_ok && hs_run > 0) chk("hsync_width", hs_run, HS);
               hs_run = 0; hs_ok = 1;
            end
            if (!HDMI_VSYNC) vs_run++;
            else begin
               if (vs_ok && vs_run > 0) chk("vsync_width", vs_run, VS * HT);
               vs_run = 0; vs_ok = 1;
            end
         end
      end
   end

   logic [14:0] de_line = 15'b000_0000_1111_1111;
   logic [14:0] hs_line = 15'b110_0011_1111_1111;

   initial begin
      step(1, 0);
      stepd(1, 0, "reset", 14, 7, 0, 1, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) stepd(0, 0, "hold_en_low", 14, 7, 0, 1, 1, 0, 0, 0);
      stepd(0, 1, "first_edge", 0, 0, 1, 1, 1, 1, 1, 1);
      for (int h = 1; h < HT; h++) stepd(0, 1, "line0", h, 0, de_line[h], hs_line[h], 1, 0, 0, 1);
      stepd(0, 1, "line1_start", 0, 1, 1, 1, 1, 1, 0, 1);
      meas = 1'b1;
      for (int i = 0; i < 2 * FRAME; i++) step(0, 1);

      run_until(5, 2);
      meas = 1'b0;
      ls_expect = HT + 7;
      for (int i = 0; i < 7; i++) stepd(0, 0, "en_low_hold", 5, 2, 1, 1, 1, 0, 0, mfc);
      stepd(0, 1, "resume", 6, 2, 1, 1, 1, 0, 0, mfc);
      meas = 1'b1;

      run_until(11, 5);
      meas = 1'b0;
      stepd(1, 1, "mid_reset", 14, 7, 0, 1, 1, 0, 0, 0);
      stepd(0, 1, "after_mid_reset", 0, 0, 1, 1, 1, 1, 1, 1);
      meas = 1'b1;

      for (int n = 0; n < 256 * FRAME + 10; n++) begin
         if (mfc == 255 && mh == HT - 1 && mv == VT - 1) break;
         step(0, 1);
      end
      stepd(0, 1, "fc_wrap", 0, 0, 1, 1, 1, 1, 1, 0);
      for (int i = 0; i < 3; i++) step(0, 1);

      repeat (3) @(negedge clk_hdmi);
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain got=%0d want=0", q.size());
      end
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
